// File: rtl/xunit_msg_sched.sv
`default_nettype none
// ============================================================================
// Module   : xunit_msg_sched
// Brief    : SHA-256 message-schedule stage. Streams a 16-word window and
//            expands it in place to the next 16 schedule words.
//            Optional K-constant ROM enabled by XUNIT_MSG_SCHED_KROM_EN.
// Revision : 1.0
// ============================================================================
module xunit_msg_sched #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DATA_W-1:0]  in1,
    input  logic [DATA_W-1:0]  in2,
    input  logic [DATA_W-1:0]  in3,
    input  logic [DATA_W-1:0]  in4,
    input  logic [DATA_W-1:0]  in5,
    input  logic [DATA_W-1:0]  in6,
    input  logic [DATA_W-1:0]  in7,
    input  logic [DATA_W-1:0]  in8,
    input  logic [DATA_W-1:0]  in9,
    input  logic [DATA_W-1:0]  in10,
    input  logic [DATA_W-1:0]  in11,
    input  logic [DATA_W-1:0]  in12,
    input  logic [DATA_W-1:0]  in13,
    input  logic [DATA_W-1:0]  in14,
    input  logic [DATA_W-1:0]  in15,
    input  logic [DELAY_W-1:0] delay0,
    output logic [DATA_W-1:0]  w_out,
    output logic               valid,
    output logic               done,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    output logic [DATA_W-1:0]  out2,
    output logic [DATA_W-1:0]  out3,
    output logic [DATA_W-1:0]  out4,
    output logic [DATA_W-1:0]  out5,
    output logic [DATA_W-1:0]  out6,
    output logic [DATA_W-1:0]  out7,
    output logic [DATA_W-1:0]  out8,
    output logic [DATA_W-1:0]  out9,
    output logic [DATA_W-1:0]  out10,
    output logic [DATA_W-1:0]  out11,
    output logic [DATA_W-1:0]  out12,
    output logic [DATA_W-1:0]  out13,
    output logic [DATA_W-1:0]  out14,
    output logic [DATA_W-1:0]  out15
`ifdef XUNIT_MSG_SCHED_KROM_EN
    ,
    output logic [DATA_W-1:0]  k_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t              state_q, state_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   win_q [16];
    logic [DATA_W-1:0]   win_d [16];
    logic [DATA_W-1:0]   w_in  [16];
    logic [DATA_W-1:0]   w_new;

    assign w_in = '{in0, in1, in2, in3, in4, in5, in6, in7,
                    in8, in9, in10, in11, in12, in13, in14, in15};

    assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        case (state_q)
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = w_in[i];
                    end
                    idx_d   = 4'd0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = w_new;
                idx_d     = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase

        // A run pulse overrides whatever the current state was doing this edge,
        // including a load or shift that would otherwise have happened.
        if (run) begin
            state_d = S_WAIT;
            cnt_d   = delay0;
            idx_d   = idx_q;
            for (int i = 0; i < 16; i++) begin
                win_d[i] = win_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign valid = (state_q == S_STREAM);
    assign done  = (state_q == S_DONE);
    assign w_out = win_q[0];

    assign out0  = win_q[0];
    assign out1  = win_q[1];
    assign out2  = win_q[2];
    assign out3  = win_q[3];
    assign out4  = win_q[4];
    assign out5  = win_q[5];
    assign out6  = win_q[6];
    assign out7  = win_q[7];
    assign out8  = win_q[8];
    assign out9  = win_q[9];
    assign out10 = win_q[10];
    assign out11 = win_q[11];
    assign out12 = win_q[12];
    assign out13 = win_q[13];
    assign out14 = win_q[14];
    assign out15 = win_q[15];

`ifdef XUNIT_MSG_SCHED_KROM_EN
    localparam logic [DATA_W-1:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Round counter survives run so consecutive runs walk K[0..63].
    logic [5:0] rnd_q, rnd_d;

    always_comb begin
        rnd_d = rnd_q;
        if (valid) begin
            rnd_d = rnd_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_q <= 6'd0;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign k_out = K_TAB[rnd_q];
`endif

endmodule
`default_nettype wire
